// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: bundles the requester-side and SPI-master-side signals of spi_arbiter.
//   slave  modport : used by the arbiter. It takes requests and the master's status, and
//                    drives grants, responses, master controls and chip selects.
//   master modport : the opposite view, for whatever drives the requests and models the master.
// Signals:
//   req / req_tx_data / req_slave_sel  per-requester request level, tx byte, target slave
//   gnt / rsp_valid                    one-hot grant and response pulses
//   rsp_rx_data / rsp_err              received byte and timeout flag
//   busy                               arbiter is not idle
//   m_start / m_tx_data                controls to the SPI master
//   m_rx_data / m_done / m_ss_n        status from the SPI master
//   ss_n_out                           active-low chip selects to the pads
interface spi_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned SEL_W      = 2
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*8-1:0]     req_tx_data;
    logic [NUM_REQ*SEL_W-1:0] req_slave_sel;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [7:0]               rsp_rx_data;
    logic                     rsp_err;
    logic                     busy;
    logic                     m_start;
    logic [7:0]               m_tx_data;
    logic [7:0]               m_rx_data;
    logic                     m_done;
    logic                     m_ss_n;
    logic [NUM_SLAVES-1:0]    ss_n_out;

    modport slave (
        input  req, req_tx_data, req_slave_sel, m_rx_data, m_done, m_ss_n,
        output gnt, rsp_valid, rsp_rx_data, rsp_err, busy, m_start, m_tx_data, ss_n_out
    );

    modport master (
        output req, req_tx_data, req_slave_sel, m_rx_data, m_done, m_ss_n,
        input  gnt, rsp_valid, rsp_rx_data, rsp_err, busy, m_start, m_tx_data, ss_n_out
    );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one SPI master between NUM_REQ requesters.
// Each transaction moves one byte. The arbiter latches the winner's tx byte and slave
// index, pulses m_start, waits for m_done, returns the received byte to the owner and
// routes the master's ss_n onto the owner's chip-select line.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   spi_arbiter_if.slave (requests, grants, responses, master link, chip selects)
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a WAIT lasting TIMEOUT_CYCLES
// cycles with rsp_err=1 and rsp_rx_data=8'h00. Without it WAIT never times out and
// rsp_err is tied to 0.
module spi_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned SEL_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic              clk,
    input logic              rst,
    spi_arbiter_if.slave     bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StResp
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [SEL_W-1:0]   owner_sel_q, owner_sel_d;
    logic [7:0]         m_tx_data_q, m_tx_data_d;
    logic [7:0]         rsp_rx_data_q, rsp_rx_data_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               m_start_q, m_start_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   win;
    logic               win_valid;
    logic [7:0]         win_tx;
    logic [SEL_W-1:0]   win_sel;
    logic [NUM_SLAVES-1:0] ss_n;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rsp_err_q, rsp_err_d;
`else
    logic               unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Round-robin pick. The scan runs from lowest to highest priority, so the last hit
    // wins; priority order is last_grant+1, last_grant+2, ... with wrap-around.
    always_comb begin
        cand      = '0;
        win       = '0;
        win_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(last_grant_q) + NUM_REQ - k) % NUM_REQ);
            if (bus.req[cand]) begin
                win       = cand;
                win_valid = 1'b1;
            end
        end
        win_tx  = '0;
        win_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win == IDX_W'(i)) begin
                win_tx  = bus.req_tx_data[i*8 +: 8];
                win_sel = bus.req_slave_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        owner_sel_d   = owner_sel_q;
        m_tx_data_d   = m_tx_data_q;
        rsp_rx_data_d = rsp_rx_data_q;
        gnt_d         = '0;
        rsp_valid_d   = '0;
        m_start_d     = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_err_d     = rsp_err_q;
`endif

        case (state_q)
            StIdle: begin
                if (win_valid) begin
                    owner_d     = win;
                    owner_sel_d = win_sel;
                    m_tx_data_d = win_tx;
                    gnt_d       = NUM_REQ'(1) << win;
                    // m_start rises together with gnt so both are seen in START.
                    m_start_d   = 1'b1;
                    state_d     = StStart;
                end
            end
            StStart: begin
                state_d = StWait;
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StWait: begin
                if (bus.m_done) begin
                    rsp_rx_data_d = bus.m_rx_data;
                    rsp_valid_d   = NUM_REQ'(1) << owner_q;
                    state_d       = StResp;
`ifdef SPI_ARB_TIMEOUT_EN
                    rsp_err_d     = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // This is the TIMEOUT_CYCLES-th WAIT cycle without m_done.
                    rsp_rx_data_d = 8'h00;
                    rsp_err_d     = 1'b1;
                    rsp_valid_d   = NUM_REQ'(1) << owner_q;
                    state_d       = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StResp: begin
                last_grant_d = owner_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            owner_q       <= '0;
            last_grant_q  <= IDX_W'(NUM_REQ - 1);
            owner_sel_q   <= '0;
            m_tx_data_q   <= 8'h00;
            rsp_rx_data_q <= 8'h00;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            m_start_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            owner_sel_q   <= owner_sel_d;
            m_tx_data_q   <= m_tx_data_d;
            rsp_rx_data_q <= rsp_rx_data_d;
            gnt_q         <= gnt_d;
            rsp_valid_q   <= rsp_valid_d;
            m_start_q     <= m_start_d;
            busy_q        <= busy_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Chip-select demux is combinational so ss_n tracks the master without a cycle lag.
    // An out-of-range owner_sel matches no line, leaving every select high.
    always_comb begin
        ss_n = '1;
        if (state_q != StIdle) begin
            for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
                if (owner_sel_q == SEL_W'(k)) begin
                    ss_n[k] = bus.m_ss_n;
                end
            end
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rx_data = rsp_rx_data_q;
    assign bus.busy        = busy_q;
    assign bus.m_start     = m_start_q;
    assign bus.m_tx_data   = m_tx_data_q;
    assign bus.ss_n_out    = ss_n;

endmodule
